ccff_chain_loader: RTL



---
 rtl/ccff_chain_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: drives one configuration-chain segment from a word stream.
// Bitstream words are serialized LSB-first onto ccff_head, and the bits leaving
// ccff_tail (the old configuration) are reassembled into readback words.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [BW-1:0]    WORD_B = BW'(WORD_W);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_W);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, req, req_n, rem;
  logic [WORD_W-1:0] wreg, wreg_n, asm_q, asm_v, asm_n, rb_data_n;
  logic [BW-1:0]     wcnt, wcnt_n, asm_cnt, ac1, asm_cnt_n, eff;
  logic              accept, issue, bitv, flush, xfer, rb_valid_n;

  // Next-state datapath: capture tail bit, move full/final word to holding,
  // pick the next head bit (bypassing a word accepted on this same edge).
  always_comb begin
    accept = s_valid && s_ready;
    cnt_n  = cnt + CNT_W'(ccff_shift_en);

    asm_v = asm_q;
    ac1   = asm_cnt;
    if (ccff_shift_en) begin
      asm_v = asm_q | (WORD_W'(ccff_tail) << asm_cnt);
      ac1   = asm_cnt + BW'(1);
    end
    // A complete word (or the final partial one) may wait in the assembly
    // register until the holding register frees up.
    flush      = (ac1 == WORD_B) || ((cnt_n == LEN_C) && (ac1 != '0));
    xfer       = flush && (!rb_valid || rb_ready);
    asm_n      = xfer ? '0 : asm_v;
    asm_cnt_n  = xfer ? '0 : ac1;
    rb_valid_n = xfer || (rb_valid && !rb_ready);
    rb_data_n  = xfer ? asm_v : rb_data;

    // Only the chain bits still owed are taken from an accepted word.
    rem  = LEN_C - req;
    eff  = (rem < WORD_C) ? BW'(rem) : WORD_B;
    bitv = (wcnt != '0) ? wreg[0] : s_data[0];
    // The issued bit lands next edge; it needs a free assembly slot then.
    issue = (state == LOAD) && ((wcnt != '0) || accept) &&
            (cnt_n < LEN_C) && (asm_cnt_n < WORD_B);

    wreg_n = wreg;
    wcnt_n = wcnt;
    req_n  = req;
    if (accept) begin
      wreg_n = issue ? (s_data >> 1) : s_data;
      wcnt_n = eff - BW'(issue);
      req_n  = req + CNT_W'(eff);
    end else if (issue) begin
      wreg_n = wreg >> 1;
      wcnt_n = wcnt - BW'(1);
    end

    state_n = state;
    case (state)
      IDLE: if (start && !abort) begin
        state_n = LOAD;
        cnt_n   = '0;
        req_n   = '0;
      end
      LOAD:    if (cnt_n == LEN_C) state_n = DRAIN;
      DRAIN:   if ((asm_cnt == '0) && !rb_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; abort outside IDLE clears like a reset.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state <= IDLE;  cnt <= '0;  req <= '0;
      wreg <= '0;  wcnt <= '0;  asm_q <= '0;  asm_cnt <= '0;
      rb_valid <= 1'b0;  rb_data <= '0;
      s_ready <= 1'b0;  ccff_head <= 1'b0;  ccff_shift_en <= 1'b0;
      busy <= 1'b0;  done <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      state <= IDLE;  cnt <= '0;  req <= '0;
      wreg <= '0;  wcnt <= '0;  asm_q <= '0;  asm_cnt <= '0;
      rb_valid <= 1'b0;  rb_data <= '0;
      s_ready <= 1'b0;  ccff_head <= 1'b0;  ccff_shift_en <= 1'b0;
      busy <= 1'b0;  done <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      req      <= req_n;
      wreg     <= wreg_n;
      wcnt     <= wcnt_n;
      asm_q    <= asm_n;
      asm_cnt  <= asm_cnt_n;
      rb_valid <= rb_valid_n;
      rb_data  <= rb_data_n;
      ccff_shift_en <= issue;
      if (issue) ccff_head <= bitv;
      s_ready  <= (state_n == LOAD) && (wcnt_n == '0) && (req_n < LEN_C);
      busy     <= (state_n != IDLE);
      done     <= (state == DRAIN) && (state_n == IDLE);
    end
  end

endmodule
